// File: rtl/fft_bitrev_framer.sv
// Ping-pong input framer that replays each N-sample frame in bit-reversed order as complex samples for an FFT core.
// Optional FFT_FRAMER_OFFSET_BIN_EN: convert offset-binary input to two's complement by inverting the MSB.
module fft_bitrev_framer #(
    parameter int N_LOG2 = 4,
    parameter int DATA_W = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   in_x,
    input  logic                in_nd,
    input  logic                out_ready,
    output logic [2*DATA_W-1:0] out_x,
    output logic                out_nd,
    output logic                out_sof,
    output logic                overflow
);
    localparam int N = 1 << N_LOG2;

    localparam logic S_IDLE   = 1'b0;
    localparam logic S_STREAM = 1'b1;

    // Both banks live in one array; the bank select is the address MSB.
    logic [DATA_W-1:0]   r_mem [0:2*N-1];
    logic [1:0]          r_full;
    logic                r_wr_bank;
    logic                r_rd_bank;
    logic [N_LOG2-1:0]   r_wr_cnt;
    logic [N_LOG2-1:0]   r_rd_cnt;
    logic                r_state;
    logic [2*DATA_W-1:0] r_out_x;
    logic                r_out_nd;
    logic                r_out_sof;
    logic                r_overflow;

    logic                w_wr_ok;
    logic                w_wr_last;
    logic                w_start;
    logic                w_rd_last;
    logic [N_LOG2:0]     w_wr_addr;
    logic [N_LOG2:0]     w_rd_addr;
    logic [1:0]          w_full_nxt;

    function automatic logic [N_LOG2-1:0] bit_rev(input logic [N_LOG2-1:0] a);
        logic [N_LOG2-1:0] v;
        v = '0;
        for (int i = 0; i < N_LOG2; i++) begin
            v[i] = a[N_LOG2-1-i];
        end
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] to_real(input logic [DATA_W-1:0] x);
`ifdef FFT_FRAMER_OFFSET_BIN_EN
        return {~x[DATA_W-1], x[DATA_W-2:0]};
`else
        return x;
`endif
    endfunction

    // A full bank is either waiting or being streamed, so the full flag alone guards writes.
    assign w_wr_ok   = in_nd & ~r_full[r_wr_bank];
    assign w_wr_last = w_wr_ok & (&r_wr_cnt);
    assign w_start   = (r_state == S_IDLE) & out_ready & r_full[r_rd_bank];
    assign w_rd_last = (r_state == S_STREAM) & (&r_rd_cnt);
    assign w_wr_addr = {r_wr_bank, r_wr_cnt};
    assign w_rd_addr = {r_rd_bank, bit_rev(r_rd_cnt)};

    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_rd_last) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok && !reset) begin
            r_mem[w_wr_addr] <= to_real(in_x);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full     <= 2'b00;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_state    <= S_IDLE;
            r_out_x    <= '0;
            r_out_nd   <= 1'b0;
            r_out_sof  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_ok) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
                if (w_wr_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (in_nd && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end

            r_out_nd  <= 1'b0;
            r_out_sof <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state  <= S_STREAM;
                        r_rd_cnt <= '0;
                    end
                end
                S_STREAM: begin
                    r_out_nd  <= 1'b1;
                    r_out_sof <= (r_rd_cnt == '0);
                    r_out_x   <= {r_mem[w_rd_addr], {DATA_W{1'b0}}};
                    r_rd_cnt  <= r_rd_cnt + 1'b1;
                    // Returning through IDLE guarantees a gap between frames.
                    if (w_rd_last) begin
                        r_state   <= S_IDLE;
                        r_rd_bank <= ~r_rd_bank;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_x    = r_out_x;
    assign out_nd   = r_out_nd;
    assign out_sof  = r_out_sof;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_fft_bitrev_framer.sv
// Directed self-checking bench for fft_bitrev_framer (N=16, DATA_W=12).
module tb_fft_bitrev_framer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] in_x = '0;
    logic        in_nd = 1'b0;
    logic        out_ready = 1'b0;
    logic [23:0] out_x;
    logic        out_nd;
    logic        out_sof;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [23:0] cap_q [$];
    logic        sof_q [$];
    int          runs_q [$];
    int          run_len = 0;

    typedef struct {
        logic [11:0] din;
        logic [23:0] exp;
    } vec_t;
    vec_t vec [16];
    int   rev [16];
    logic [11:0] fr [16];

    fft_bitrev_framer #(.N_LOG2(4), .DATA_W(12)) dut (
        .clk(clk), .reset(reset), .in_x(in_x), .in_nd(in_nd), .out_ready(out_ready),
        .out_x(out_x), .out_nd(out_nd), .out_sof(out_sof), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_nd) begin
            cap_q.push_back(out_x);
            sof_q.push_back(out_sof);
            run_len = run_len + 1;
        end else if (run_len != 0) begin
            runs_q.push_back(run_len);
            run_len = 0;
        end
    end

    function automatic logic [11:0] fix(input logic [11:0] x);
`ifdef FFT_FRAMER_OFFSET_BIN_EN
        return x ^ 12'h800;
`else
        return x;
`endif
    endfunction

    function automatic logic [23:0] cplx(input logic [11:0] x);
        return {fix(x), 12'h000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_q();
        cap_q.delete();
        sof_q.delete();
        runs_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_nd = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        clear_q();
    endtask

    task automatic wait_runs(input int n, input int budget, input string nm);
        int c;
        c = 0;
        while (runs_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk(nm, runs_q.size(), n);
    endtask

    task automatic feed(input logic [11:0] v);
        in_x  = v;
        in_nd = 1'b1;
        tick();
        in_nd = 1'b0;
    endtask

    initial begin
        int sof_cnt;
        int sz;
        int c;

        rev = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        vec[0]  = '{12'd50,  24'h032000};  vec[1]  = '{12'd115, 24'h0C8000};
        vec[2]  = '{12'd43,  24'h002000};  vec[3]  = '{12'd20,  24'h049000};
        vec[4]  = '{12'd2,   24'h02B000};  vec[5]  = '{12'd13,  24'h050000};
        vec[6]  = '{12'd115, 24'h073000};  vec[7]  = '{12'd20,  24'h384000};
        vec[8]  = '{12'd200, 24'h073000};  vec[9]  = '{12'd46,  24'h02E000};
        vec[10] = '{12'd80,  24'h00D000};  vec[11] = '{12'd92,  24'h03E000};
        vec[12] = '{12'd73,  24'h014000};  vec[13] = '{12'd62,  24'h05C000};
        vec[14] = '{12'd900, 24'h014000};  vec[15] = '{12'd1,   24'h001000};
        for (int k = 0; k < 16; k++) fr[k] = 12'(300 + k);
        fr[0] = 12'h800;
        fr[8] = 12'h7FF;

        // Reset state
        reset = 1'b1;
        tick();
        chk("rst_out_x", out_x, 0);
        chk("rst_out_nd", out_nd, 0);
        chk("rst_out_sof", out_sof, 0);
        chk("rst_overflow", overflow, 0);

        // Single frame, table-driven
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_x  = vec[i].din;
            in_nd = 1'b1;
            tick();
        end
        in_nd = 1'b0;
        wait_runs(1, 60, "t1_runs");
        chk("t1_count", cap_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < cap_q.size())
                chk($sformatf("t1_out%0d", i), cap_q[i], {fix(vec[i].exp[23:12]), 12'h000});
        end
        sof_cnt = 0;
        foreach (sof_q[i]) sof_cnt += int'(sof_q[i]);
        chk("t1_sof_first", (sof_q.size() > 0) ? sof_q[0] : 1'b0, 1);
        chk("t1_sof_count", sof_cnt, 1);
        if (runs_q.size() > 0) chk("t1_run_len", runs_q[0], 16);
        tick();
        chk("t1_hold_nd", out_nd, 0);
        chk("t1_hold_x", out_x, cplx(12'd1));
        chk("t1_overflow", overflow, 0);

        // Overflow with out_ready low, then two streamed frames
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 33; k++) begin
            feed(12'(k + 1));
            if (k == 31) chk("t2_ovf_before", overflow, 0);
            if (k == 32) chk("t2_ovf_after", overflow, 1);
        end
        tick();
        tick();
        chk("t2_no_out_not_ready", cap_q.size(), 0);
        out_ready = 1'b1;
        wait_runs(2, 120, "t2_runs");
        chk("t2_count", cap_q.size(), 32);
        if (runs_q.size() >= 2) begin
            chk("t2_run0", runs_q[0], 16);
            chk("t2_run1", runs_q[1], 16);
        end
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < 16; j++) begin
                if (16 * f + j < cap_q.size())
                    chk($sformatf("t2_f%0d_out%0d", f, j), cap_q[16*f+j], cplx(12'(16*f + rev[j] + 1)));
            end
        end
        chk("t2_ovf_sticky", overflow, 1);

        // Continuous input
        do_reset();
        chk("t3_ovf_cleared", overflow, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            in_x  = 12'(100 + k);
            in_nd = 1'b1;
            tick();
        end
        in_nd = 1'b0;
        wait_runs(2, 120, "t3_runs");
        chk("t3_count", cap_q.size(), 32);
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < 16; j++) begin
                if (16 * f + j < cap_q.size())
                    chk($sformatf("t3_f%0d_out%0d", f, j), cap_q[16*f+j], cplx(12'(100 + 16*f + rev[j])));
            end
        end
        chk("t3_overflow", overflow, 0);

        // Reset at write count 7, then during output r=5
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) feed(12'(200 + k));
        reset = 1'b1;
        tick();
        chk("t4_nd_after_rst_wr", out_nd, 0);
        reset = 1'b0;
        for (int k = 0; k < 9; k++) feed(fr[k]);
        for (int k = 0; k < 40; k++) tick();
        chk("t4_no_frame_partial", cap_q.size(), 0);
        for (int k = 9; k < 16; k++) feed(fr[k]);
        c = 0;
        while (cap_q.size() < 5 && c < 60) begin
            tick();
            c++;
        end
        chk("t4_stream_started", (cap_q.size() >= 5) ? 1 : 0, 1);
        reset = 1'b1;
        tick();
        chk("t4_nd_after_rst_rd", out_nd, 0);
        sz = cap_q.size();
        reset = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (j < cap_q.size())
                chk($sformatf("t4_out%0d", j), cap_q[j], cplx(fr[rev[j]]));
        end
        for (int k = 0; k < 40; k++) tick();
        chk("t4_no_out_after_rst", cap_q.size(), sz);
        chk("t4_frame_truncated", (sz < 16) ? 1 : 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
